// File: rtl/instr_mem_pipelined_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_mem_pipelined_if                                                     |
// | Fetch request/response and program-load signals of the instruction memory. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface instr_mem_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
);
  logic                  reqValid;
  logic                  reqReady;
  logic [ADDR_WIDTH-1:0] reqAddress;
  logic                  rspValid;
  logic                  rspReady;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  rspError;
  logic                  loadEnable;
  logic [ADDR_WIDTH-1:0] loadAddress;
  logic [DATA_WIDTH-1:0] loadData;

  modport master (
    output reqValid, reqAddress, rspReady, loadEnable, loadAddress, loadData,
    input  reqReady, rspValid, instruction, rspError
  );

  modport slave (
    input  reqValid, reqAddress, rspReady, loadEnable, loadAddress, loadData,
    output reqReady, rspValid, instruction, rspError
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_mem_pipelined                                                        |
// | Byte-addressed instruction memory with a LATENCY-deep stallable read pipe. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_mem_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  instr_mem_pipelined_if.slave  bus
);
  localparam int                    c_off   = $clog2(DATA_WIDTH / 8);
  localparam int                    c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_depth = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [LATENCY-1:0]    r_valid;
  logic [DATA_WIDTH-1:0] r_data [LATENCY];
  logic [LATENCY-1:0]    r_err;

  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic [ADDR_WIDTH-1:0] w_ld_idx;
  logic                  w_req_mis;
  logic                  w_ld_mis;
  logic                  w_req_bad;
  logic                  w_ld_ok;
  logic                  w_stall;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Range check uses the full-width index so high address bits never alias.
  assign w_req_idx = bus.reqAddress >> c_off;
  assign w_ld_idx  = bus.loadAddress >> c_off;

  generate
    if (c_off == 0) begin : g_byte_words
      assign w_req_mis = 1'b0;
      assign w_ld_mis  = 1'b0;
    end else begin : g_multi_byte_words
      assign w_req_mis = |bus.reqAddress[c_off-1:0];
      assign w_ld_mis  = |bus.loadAddress[c_off-1:0];
    end
  endgenerate

  assign w_req_bad = w_req_mis | (w_req_idx >= c_depth);
  assign w_ld_ok   = bus.loadEnable & ~w_ld_mis & (w_ld_idx < c_depth);

  assign w_stall      = r_valid[LATENCY-1] & ~bus.rspReady;
  assign w_accept     = bus.reqValid & ~w_stall;
  assign bus.reqReady = ~w_stall;

  assign w_rd_data = w_req_bad ? '0 : r_mem[w_req_idx[c_iw-1:0]];

  // Array is deliberately outside reset so a program survives a CPU reset.
  always_ff @(posedge clock) begin
    if (w_ld_ok) begin
      r_mem[w_ld_idx[c_iw-1:0]] <= bus.loadData;
    end
  end

  // Stage 0 samples the array at the accepting edge, giving read-before-write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_data[s] <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= w_accept;
      r_err[0]   <= w_accept & w_req_bad;
      r_data[0]  <= w_accept ? w_rd_data : '0;
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_err[s]   <= r_err[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign bus.rspValid    = r_valid[LATENCY-1];
  assign bus.rspError    = r_err[LATENCY-1];
  assign bus.instruction = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_mem_pipelined                                                     |
// | Directed bench over LATENCY = 1, 2 and 3 instances sharing one stimulus.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_mem_pipelined;
  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  sel     = 2'd1;

  logic        req_valid = 1'b0;
  logic [63:0] req_addr  = '0;
  logic        rsp_ready = 1'b1;
  logic        load_en   = 1'b0;
  logic [63:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] words [4] = '{32'h8B1F03E5, 32'hF84000A4, 32'h8B040086, 32'hF80010A6};

  always #5 clock = ~clock;

  instr_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(64)) bus1 ();
  instr_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(64)) bus2 ();
  instr_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(64)) bus3 ();

  instr_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(1024), .LATENCY(1))
    u_dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1.slave));
  instr_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(1024), .LATENCY(2))
    u_dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2.slave));
  instr_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(1024), .LATENCY(3))
    u_dut3 (.clock(clock), .reset_n(reset_n), .bus(bus3.slave));

  // Only the selected instance sees requests/loads; the others stay idle.
  assign bus1.reqValid    = (sel == 2'd1) & req_valid;
  assign bus2.reqValid    = (sel == 2'd2) & req_valid;
  assign bus3.reqValid    = (sel == 2'd3) & req_valid;
  assign bus1.rspReady    = (sel == 2'd1) ? rsp_ready : 1'b1;
  assign bus2.rspReady    = (sel == 2'd2) ? rsp_ready : 1'b1;
  assign bus3.rspReady    = (sel == 2'd3) ? rsp_ready : 1'b1;
  assign bus1.loadEnable  = (sel == 2'd1) & load_en;
  assign bus2.loadEnable  = (sel == 2'd2) & load_en;
  assign bus3.loadEnable  = (sel == 2'd3) & load_en;
  assign bus1.reqAddress  = req_addr;
  assign bus2.reqAddress  = req_addr;
  assign bus3.reqAddress  = req_addr;
  assign bus1.loadAddress = load_addr;
  assign bus2.loadAddress = load_addr;
  assign bus3.loadAddress = load_addr;
  assign bus1.loadData    = load_data;
  assign bus2.loadData    = load_data;
  assign bus3.loadData    = load_data;

  always_comb begin
    req_ready = bus1.reqReady;
    rsp_valid = bus1.rspValid;
    rsp_instr = bus1.instruction;
    rsp_err   = bus1.rspError;
    case (sel)
      2'd2: begin
        req_ready = bus2.reqReady;
        rsp_valid = bus2.rspValid;
        rsp_instr = bus2.instruction;
        rsp_err   = bus2.rspError;
      end
      2'd3: begin
        req_ready = bus3.reqReady;
        rsp_valid = bus3.rspValid;
        rsp_instr = bus3.instruction;
        rsp_err   = bus3.rspError;
      end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input logic [63:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic fetch_one(input string tag, input logic [63:0] addr, input int lat,
                           input logic [31:0] exp_data, input logic exp_err);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    repeat (lat - 1) step();
    check_val({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check_val({tag, "_instr"}, 64'(rsp_instr), 64'(exp_data));
    check_val({tag, "_err"},   64'(rsp_err),   64'(exp_err));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for three cycles with a request pending.
    sel       = 2'd1;
    req_valid = 1'b1;
    req_addr  = 64'h0;
    repeat (3) step();
    check_val("rst_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_instr", 64'(rsp_instr), 64'd0);
    check_val("rst_err",   64'(rsp_err),   64'd0);
    reset_n   = 1'b1;
    req_valid = 1'b0;
    #1;
    check_val("rst_ready", 64'(req_ready), 64'd1);
    step();
    check_val("rst_no_emit", 64'(rsp_valid), 64'd0);

    // LATENCY=1: load then back-to-back fetch.
    for (int i = 0; i < 4; i++) load(64'(4 * i), words[i]);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'(4 * i);
      step();
      check_val($sformatf("l1_valid%0d", i), 64'(rsp_valid), 64'd1);
      check_val($sformatf("l1_instr%0d", i), 64'(rsp_instr), 64'(words[i]));
      check_val($sformatf("l1_err%0d", i),   64'(rsp_err),   64'd0);
    end
    req_valid = 1'b0;
    step();
    check_val("l1_drain", 64'(rsp_valid), 64'd0);

    // Error fetches and ignored loads.
    fetch_one("mis6",   64'h6,           1, 32'h0, 1'b1);
    fetch_one("oor",    64'd4096,        1, 32'h0, 1'b1);
    fetch_one("alias",  64'h1_0000_0000, 1, 32'h0, 1'b1);
    load(64'h2, 32'hDEADBEEF);
    load(64'd4096, 32'hCAFEF00D);
    fetch_one("misld",  64'h0,           1, words[0], 1'b0);
    load(64'hFFC, 32'hA5A5A5A5);
    fetch_one("last",   64'hFFC,         1, 32'hA5A5A5A5, 1'b0);

    // Same-cycle load and fetch of one word returns the old contents.
    load(64'h8, 32'h11111111);
    load_en   = 1'b1;
    load_addr = 64'h8;
    load_data = 32'h22222222;
    req_valid = 1'b1;
    req_addr  = 64'h8;
    step();
    load_en   = 1'b0;
    req_valid = 1'b0;
    check_val("rbw_old", 64'(rsp_instr), 64'h11111111);
    step();
    fetch_one("rbw_new", 64'h8, 1, 32'h22222222, 1'b0);

    // LATENCY=3 with backpressure.
    sel = 2'd3;
    for (int i = 0; i < 4; i++) load(64'(4 * i), words[i]);
    req_valid = 1'b1;
    req_addr  = 64'h0;
    step();
    req_addr  = 64'h4;
    step();
    check_val("l3_early", 64'(rsp_valid), 64'd0);
    req_addr  = 64'h8;
    step();
    check_val("l3_first_v", 64'(rsp_valid), 64'd1);
    check_val("l3_first_d", 64'(rsp_instr), 64'(words[0]));
    req_addr  = 64'hC;
    rsp_ready = 1'b0;
    #1;
    check_val("l3_stall_rdy", 64'(req_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_val($sformatf("l3_hold_v%0d", i), 64'(rsp_valid), 64'd1);
      check_val($sformatf("l3_hold_d%0d", i), 64'(rsp_instr), 64'(words[0]));
      check_val($sformatf("l3_hold_r%0d", i), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check_val("l3_resume_rdy", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check_val($sformatf("l3_seq_v%0d", i), 64'(rsp_valid), 64'd1);
      check_val($sformatf("l3_seq_d%0d", i), 64'(rsp_instr), 64'(words[i]));
      step();
    end
    check_val("l3_end", 64'(rsp_valid), 64'd0);

    // LATENCY=2: reset pulse with two requests in flight.
    sel = 2'd2;
    load(64'h0, words[0]);
    load(64'h4, words[1]);
    req_valid = 1'b1;
    req_addr  = 64'h0;
    step();
    req_addr  = 64'h4;
    @(posedge clock);
    #2;
    check_val("l2_pre_rst", 64'(rsp_valid), 64'd1);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    check_val("l2_rst_v", 64'(rsp_valid), 64'd0);
    check_val("l2_rst_d", 64'(rsp_instr), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("l2_stale%0d", i), 64'(rsp_valid), 64'd0);
    end
    fetch_one("l2_keep", 64'h4, 2, words[1], 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
